rr_grant_mux_buf: RTL and testbench
===================================

// Module: rr_grant_mux_buf
// PURPOSE
//  Downstream stage of the round-robin arbiter. Consumes the arbiter's registered one-hot grant.
//  Selects the granted requester's payload and returns a one-cycle ack to that requester.
//  Queues the transfer in a 2-entry in-order buffer, then presents it on a valid/ready master port.
//  Exports a full flag so requesters gate their request lines while the buffer cannot accept.
// PARAMETERS
//  N    6  number of requesters; must match the arbiter's N (N>=2)
//  W    8  payload width per requester, in bits
//  IW   $clog2(N)  source-index width (derived localparam, not overridable)
// PORTS
//  clk       in   1    rising-edge clock
//  rst_n     in   1    asynchronous active-low reset
//  gnt       in   N    one-hot grant from the arbiter output; all-zero means no grant
//  req_data  in   N*W  payloads; requester k occupies bits [k*W +: W]
//  ack       out  N    combinational; ack[k]=1 in the cycle requester k's payload is captured
//  full      out  1    registered; 1 when the buffer holds 2 entries
//  m_valid   out  1    registered; output entry valid
//  m_data    out  W    payload at the head of the buffer
//  m_src     out  IW   requester index of the head entry
//  m_ready   in   1    downstream accept
//  drop_err  out  1    sticky; a grant arrived and could not be accepted
//  mh_err    out  1    sticky; a multi-hot grant was seen (only meaningful with ARB_MUX_ONEHOT_CHK_EN)
// BEHAVIOUR
//  - Reset: buffer empty; m_valid=0, full=0, m_data=0, m_src=0, drop_err=0, mh_err=0; ack=0 because gnt is ignored while rst_n=0.
//  - pop  = m_valid & m_ready.
//  - push = (gnt!=0) & accept, where accept = !full | pop. A full buffer accepts a push in the same cycle as a pop.
//  - On push: ack[idx]=1, and {req_data[idx], idx} is written at the tail. idx is the set bit of gnt.
//  - Latency: a grant in cycle t into an empty buffer gives m_valid=1 at t+1, with that entry's data and src.
//  - Entries leave in the order they were captured. m_data and m_src stay stable while m_valid & !m_ready.
//  - Occupancy FSM: EMPTY -> ONE on push only. ONE -> FULL on push only. ONE -> EMPTY on pop only.
//    FULL -> ONE on pop only. Push+pop together in ONE or FULL keeps the state; in FULL the head advances.
//  - The state never goes past FULL.
//  - Grant while the buffer is full and no pop: no capture, ack=0, drop_err set. drop_err clears only on reset.
//    The arbiter has no back-pressure, so requesters must gate their requests with full.
//  - gnt=0: no push and no ack. Buffer contents stay unchanged apart from a pop.
//  - If reset is asserted mid-stream, in-flight entries are discarded immediately and asynchronously. No output glitches back to stale data.
//  - m_data and m_src are 0 whenever m_valid=0.
// CONFIGURATION
//  Macro ARB_MUX_ONEHOT_CHK_EN:
//   defined:
//    - A gnt with more than one bit set is treated as illegal: no push, ack=0, mh_err set (sticky).
//   undefined:
//    - A multi-hot gnt is resolved to its lowest set bit and pushed normally.
//    - mh_err is tied to 0 and there is no checker logic.
// STRUCTURE
//  - Package rr_arb_pkg:
//    - occupancy enum {OCC_EMPTY, OCC_ONE, OCC_FULL}
//    - function onehot_to_idx (lowest set bit)
//    - function is_onehot
//    - default-N constant shared with the arbiter
//  - Sub-module rr_skid_fifo2: 2-entry FIFO of {src,data} with push/pop/full/valid.
//  - The top level holds the grant decode, payload mux, ack generation and error flags.
// TESTING
//  1. Reset: hold rst_n=0 with gnt=6'b000100 -> ack=0, m_valid=0, full=0, both err flags 0.
//  2. Single grant: gnt=6'b000100, req_data[2]=8'hA5, m_ready=1 -> ack=6'b000100 in that cycle;
//     next cycle m_valid=1, m_data=8'hA5, m_src=2.
//  3. Fill and stall: m_ready=0, grants to 1 then 4 -> full=1 after the 2nd.
//     Then a grant to 0 -> ack=0, drop_err=1. Raise m_ready: outputs src 1 then 4; src 0 never appears.
//  4. Full with simultaneous pop: buffer holds {1,4}, m_ready=1, gnt to 5 -> ack[5]=1, full stays 1, outputs 1,4,5 in order.
//  5. Multi-hot: gnt=6'b010010 -> with the macro: ack=0, mh_err=1, no push.
//     Without the macro: ack=6'b000010, entry src=1 pushed.
//  6. Reset mid-stream: buffer full, pulse rst_n low -> m_valid=0 and full=0 immediately.
//     After release, a grant to 3 gives m_src=3 one cycle later.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter and its downstream grant mux/buffer stage.
package rr_arb_pkg;

    localparam int ARB_N_DEFAULT = 6;
    localparam int MAX_N         = 32;
    localparam int MAX_IW        = 5;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_FULL
    } occ_e;

    // Lowest set bit wins, so a multi-hot vector resolves deterministically.
    function automatic logic [MAX_IW-1:0] onehot_to_idx(input logic [MAX_N-1:0] v);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (v[i]) idx = MAX_IW'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/rr_skid_fifo2.sv
// Two-entry in-order FIFO of {src, data}; head output is forced to zero while empty.
module rr_skid_fifo2
    import rr_arb_pkg::*;
#(
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [IW-1:0] push_src_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          valid_o,
    output logic [IW-1:0] head_src_o,
    output logic [W-1:0]  head_data_o
);

    occ_e            occ_q, occ_d;
    logic            rd_q, rd_d;
    logic            valid_q, full_q;
    logic            push_eff, pop_eff, wr_idx;
    logic [IW-1:0]   src_q  [2];
    logic [W-1:0]    data_q [2];

    assign pop_eff  = pop_i & valid_q;
    assign push_eff = push_i & (!full_q | pop_eff);

    // In FULL the freed head slot is exactly where the new tail lands.
    assign wr_idx = (occ_q == OCC_ONE) ? ~rd_q : rd_q;

    always_comb begin
        occ_d = occ_q;
        rd_d  = rd_q;
        if (pop_eff) rd_d = ~rd_q;
        unique case (occ_q)
            OCC_EMPTY: if (push_eff) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push_eff && !pop_eff)      occ_d = OCC_FULL;
                else if (pop_eff && !push_eff) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop_eff && !push_eff) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= OCC_EMPTY;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                src_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            occ_q   <= occ_d;
            rd_q    <= rd_d;
            valid_q <= (occ_d != OCC_EMPTY);
            full_q  <= (occ_d == OCC_FULL);
            if (push_eff) begin
                src_q[wr_idx]  <= push_src_i;
                data_q[wr_idx] <= push_data_i;
            end
        end
    end

    assign valid_o     = valid_q;
    assign full_o      = full_q;
    assign head_src_o  = valid_q ? src_q[rd_q]  : '0;
    assign head_data_o = valid_q ? data_q[rd_q] : '0;

endmodule

// File: rtl/rr_grant_mux_buf.sv
// Grant decode, payload mux, ack and error flags in front of a 2-entry output buffer.
// Optional macro ARB_MUX_ONEHOT_CHK_EN rejects multi-hot grants and raises mh_err.
module rr_grant_mux_buf
    import rr_arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          gnt,
    input  logic [N*W-1:0]        req_data,
    output logic [N-1:0]          ack,
    output logic                  full,
    output logic                  m_valid,
    output logic [W-1:0]          m_data,
    output logic [$clog2(N)-1:0]  m_src,
    input  logic                  m_ready,
    output logic                  drop_err,
    output logic                  mh_err
);

    localparam int IW = $clog2(N);

    logic [MAX_N-1:0] gnt_ext;
    logic [IW-1:0]    idx;
    logic [W-1:0]     payload;
    logic             gnt_any, gnt_ok, accept, pop, push;
    logic             drop_err_q;

    always_comb begin
        gnt_ext         = '0;
        gnt_ext[N-1:0]  = gnt;
    end

    // Grant is ignored entirely while reset is held so ack stays low.
    assign gnt_any = rst_n & (gnt != '0);
`ifdef ARB_MUX_ONEHOT_CHK_EN
    assign gnt_ok  = gnt_any & is_onehot(gnt_ext);
`else
    assign gnt_ok  = gnt_any;
`endif

    assign idx     = IW'(onehot_to_idx(gnt_ext));
    assign payload = req_data[int'(idx)*W +: W];
    assign pop     = m_valid & m_ready;
    assign accept  = !full | pop;
    assign push    = gnt_ok & accept;

    always_comb begin
        ack = '0;
        if (push) ack[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_q <= 1'b0;
        end else if (gnt_ok && !accept) begin
            drop_err_q <= 1'b1;
        end
    end
    assign drop_err = drop_err_q;

`ifdef ARB_MUX_ONEHOT_CHK_EN
    logic mh_err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh_err_q <= 1'b0;
        end else if (gnt_any && !gnt_ok) begin
            mh_err_q <= 1'b1;
        end
    end
    assign mh_err = mh_err_q;
`else
    assign mh_err = 1'b0;
`endif

    rr_skid_fifo2 #(
        .W  (W),
        .IW (IW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_src_i  (idx),
        .push_data_i (payload),
        .pop_i       (pop),
        .full_o      (full),
        .valid_o     (m_valid),
        .head_src_o  (m_src),
        .head_data_o (m_data)
    );

endmodule

// File: tb/tb_rr_grant_mux_buf.sv
// Directed self-checking bench for rr_grant_mux_buf; inputs change and outputs are sampled on negedges.
module tb_rr_grant_mux_buf;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int IW = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   gnt;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           full;
    logic           m_valid;
    logic [W-1:0]   m_data;
    logic [IW-1:0]  m_src;
    logic           m_ready;
    logic           drop_err;
    logic           mh_err;

    int checks = 0;
    int errors = 0;

    rr_grant_mux_buf #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt      (gnt),
        .req_data (req_data),
        .ack      (ack),
        .full     (full),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_ready  (m_ready),
        .drop_err (drop_err),
        .mh_err   (mh_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester k carries 8'h10 + k*8'h11: 10,21,32,43,54,65.
    task automatic load_default_data();
        req_data = {8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gnt = 6'b000100; m_ready = 1'b0; load_default_data();
        #1;
        checks++; if (ack !== 6'b0) begin errors++; $display("[TB] FAIL reset_ack got %b want 000000", ack); end
        repeat (2) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", m_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
        checks++; if (drop_err !== 1'b0 || mh_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b%b want 00", drop_err, mh_err); end
        checks++; if (m_data !== 8'h00 || m_src !== 3'd0) begin errors++; $display("[TB] FAIL reset_head got %h/%0d want 00/0", m_data, m_src); end
        checks++; if (ack !== 6'b0) begin errors++; $display("[TB] FAIL reset_ack_held got %b want 000000", ack); end
        rst_n = 1'b1; gnt = '0;
    endtask

    task automatic test_single();
        req_data[2*W +: W] = 8'hA5;
        gnt = 6'b000100; m_ready = 1'b1;
        #1;
        checks++; if (ack !== 6'b000100) begin errors++; $display("[TB] FAIL single_ack got %b want 000100", ack); end
        @(negedge clk); gnt = '0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b want 1", m_valid); end
        checks++; if (m_data !== 8'hA5) begin errors++; $display("[TB] FAIL single_data got %h want a5", m_data); end
        checks++; if (m_src !== 3'd2) begin errors++; $display("[TB] FAIL single_src got %0d want 2", m_src); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00) begin errors++; $display("[TB] FAIL single_drain got %b/%h want 0/00", m_valid, m_data); end
        load_default_data();
    endtask

    task automatic test_fill_stall();
        m_ready = 1'b0; gnt = 6'b000010;
        #1;
        checks++; if (ack !== 6'b000010) begin errors++; $display("[TB] FAIL fill_ack1 got %b want 000010", ack); end
        @(negedge clk); gnt = 6'b010000;
        #1;
        checks++; if (ack !== 6'b010000) begin errors++; $display("[TB] FAIL fill_ack4 got %b want 010000", ack); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL fill_one_full got %b want 0", full); end
        @(negedge clk);
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %b want 1", full); end
        checks++; if (m_src !== 3'd1 || m_data !== 8'h21) begin errors++; $display("[TB] FAIL fill_head got %0d/%h want 1/21", m_src, m_data); end
        gnt = 6'b000001;
        #1;
        checks++; if (ack !== 6'b0) begin errors++; $display("[TB] FAIL drop_ack got %b want 000000", ack); end
        @(negedge clk); gnt = '0;
        checks++; if (drop_err !== 1'b1) begin errors++; $display("[TB] FAIL drop_err got %b want 1", drop_err); end
        checks++; if (full !== 1'b1 || m_src !== 3'd1) begin errors++; $display("[TB] FAIL stall_hold got %b/%0d want 1/1", full, m_src); end
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_src !== 3'd4 || m_data !== 8'h54) begin errors++; $display("[TB] FAIL stall_second got %b/%0d/%h want 1/4/54", m_valid, m_src, m_data); end
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL stall_unfull got %b want 0", full); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_empty got %b want 0", m_valid); end
    endtask

    task automatic test_full_pop();
        m_ready = 1'b0; gnt = 6'b000010;
        @(negedge clk); gnt = 6'b010000;
        @(negedge clk);
        checks++; if (full !== 1'b1 || m_src !== 3'd1) begin errors++; $display("[TB] FAIL fp_setup got %b/%0d want 1/1", full, m_src); end
        m_ready = 1'b1; gnt = 6'b100000;
        #1;
        checks++; if (ack !== 6'b100000) begin errors++; $display("[TB] FAIL fp_ack got %b want 100000", ack); end
        @(negedge clk); gnt = '0;
        checks++; if (full !== 1'b1 || m_src !== 3'd4) begin errors++; $display("[TB] FAIL fp_second got %b/%0d want 1/4", full, m_src); end
        @(negedge clk);
        checks++; if (full !== 1'b0 || m_valid !== 1'b1 || m_src !== 3'd5 || m_data !== 8'h65) begin errors++; $display("[TB] FAIL fp_third got %b/%b/%0d/%h want 0/1/5/65", full, m_valid, m_src, m_data); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL fp_empty got %b want 0", m_valid); end
        checks++; if (drop_err !== 1'b1) begin errors++; $display("[TB] FAIL drop_sticky got %b want 1", drop_err); end
    endtask

    task automatic test_multihot();
        m_ready = 1'b0; gnt = 6'b010010;
        #1;
`ifdef ARB_MUX_ONEHOT_CHK_EN
        checks++; if (ack !== 6'b0) begin errors++; $display("[TB] FAIL mh_ack got %b want 000000", ack); end
        @(negedge clk); gnt = '0;
        checks++; if (mh_err !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mh_reject got %b/%b want 1/0", mh_err, m_valid); end
`else
        checks++; if (ack !== 6'b000010) begin errors++; $display("[TB] FAIL mh_ack got %b want 000010", ack); end
        @(negedge clk); gnt = '0;
        checks++; if (m_valid !== 1'b1 || m_src !== 3'd1 || m_data !== 8'h21) begin errors++; $display("[TB] FAIL mh_push got %b/%0d/%h want 1/1/21", m_valid, m_src, m_data); end
        checks++; if (mh_err !== 1'b0) begin errors++; $display("[TB] FAIL mh_err_tied got %b want 0", mh_err); end
`endif
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL mh_drain got %b want 0", m_valid); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0; gnt = 6'b000010;
        @(negedge clk); gnt = 6'b000100;
        @(negedge clk); gnt = '0;
        checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL rm_setup got %b want 1", full); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("[TB] FAIL rm_async got %b/%b want 0/0", m_valid, full); end
        checks++; if (m_data !== 8'h00 || m_src !== 3'd0 || drop_err !== 1'b0) begin errors++; $display("[TB] FAIL rm_clear got %h/%0d/%b want 00/0/0", m_data, m_src, drop_err); end
        @(negedge clk);
        rst_n = 1'b1; gnt = 6'b001000;
        #1;
        checks++; if (ack !== 6'b001000) begin errors++; $display("[TB] FAIL rm_ack got %b want 001000", ack); end
        @(negedge clk); gnt = '0;
        checks++; if (m_valid !== 1'b1 || m_src !== 3'd3 || m_data !== 8'h43) begin errors++; $display("[TB] FAIL rm_after got %b/%0d/%h want 1/3/43", m_valid, m_src, m_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_full_pop();
        test_multihot();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
